// File: rtl/hummingbirdv2_spi_tx_sequencer.sv
// APB-programmed TX sequencer: queues words in a small FIFO and streams them to an
// SPI core as one chip-select framed transfer (setup, send, wait-for-EOT, hold).
module hummingbirdv2_spi_tx_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  REG_CMD    = 4'b0000,
  parameter logic [3:0]  REG_STATUS = 4'b0001,
  parameter logic [3:0]  REG_TXFIFO = 4'b0110
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [31:0] spi_data_tx,
  output logic        spi_data_tx_valid,
  input  logic        spi_data_tx_ready,
  output logic        spi_start,
  input  logic        spi_eot,
  output logic        spi_csn,
  output logic        fifo_overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {IDLE, CS_SETUP, SEND, WAIT_EOT, CS_HOLD} state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic            wr_stb, push_req, cmd_wr, start_req, ovf_clr;
  logic            full, empty, pop, push_ok, busy;
  logic            csn_nxt, start_nxt, valid_nxt;

  // APB decode: strobe and exact address must both match
  assign wr_stb    = PSEL & PENABLE & PWRITE;
  assign push_req  = wr_stb & (PADDR == REG_TXFIFO);
  assign cmd_wr    = wr_stb & (PADDR == REG_CMD);
  assign start_req = cmd_wr & PWDATA[0];
  assign ovf_clr   = cmd_wr & PWDATA[1];

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop     = (state == SEND) & spi_data_tx_ready & ~empty;
  // A pop at the same edge frees the slot, so a push at full still lands
  assign push_ok = push_req & (~full | pop);
  assign busy    = (state != IDLE);
  assign PREADY  = 1'b1;

  assign spi_data_tx = spi_data_tx_valid ? mem[rd_ptr] : '0;

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && (PADDR == REG_STATUS))
      PRDATA = {26'b0, 4'(level), busy, fifo_overflow};
  end

  // Next-state logic; registered outputs are decoded from the next state
  always_comb begin
    state_nxt = state;
    csn_nxt   = 1'b1;
    start_nxt = 1'b0;
    valid_nxt = 1'b0;
    case (state)
      IDLE:     if (start_req && !empty) state_nxt = CS_SETUP;
      CS_SETUP: state_nxt = SEND;
      SEND:     if (pop && (level == LW'(1)) && !push_ok) state_nxt = WAIT_EOT;
      WAIT_EOT: if (spi_eot) state_nxt = CS_HOLD;
      CS_HOLD:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    csn_nxt   = (state_nxt == IDLE);
    start_nxt = (state_nxt == CS_SETUP);
    valid_nxt = (state_nxt == SEND);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state             <= IDLE;
      spi_csn           <= 1'b1;
      spi_start         <= 1'b0;
      spi_data_tx_valid <= 1'b0;
    end else begin
      state             <= state_nxt;
      spi_csn           <= csn_nxt;
      spi_start         <= start_nxt;
      spi_data_tx_valid <= valid_nxt;
    end
  end

  // FIFO pointers, level and sticky overflow
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (ovf_clr)
        fifo_overflow <= 1'b0;
      else if (push_req && full && !pop)
        fifo_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible while valid is high
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr] <= PWDATA;
  end

endmodule

// File: tb/tb_hummingbirdv2_spi_tx_sequencer.sv
// Directed + randomized bench for hummingbirdv2_spi_tx_sequencer; a word queue
// models the FIFO and every handshaked word is checked against it in order.
module tb_hummingbirdv2_spi_tx_sequencer;

  localparam int unsigned DEPTH      = 4;
  localparam logic [3:0]  REG_CMD    = 4'b0000;
  localparam logic [3:0]  REG_STATUS = 4'b0001;
  localparam logic [3:0]  REG_TXFIFO = 4'b0110;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [3:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [31:0] spi_data_tx;
  logic        spi_data_tx_valid;
  logic        spi_data_tx_ready;
  logic        spi_start;
  logic        spi_eot;
  logic        spi_csn;
  logic        fifo_overflow;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] q[$];
  logic        ovf_m = 1'b0;

  hummingbirdv2_spi_tx_sequencer #(
    .FIFO_DEPTH(DEPTH), .REG_CMD(REG_CMD), .REG_STATUS(REG_STATUS), .REG_TXFIFO(REG_TXFIFO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .spi_data_tx(spi_data_tx), .spi_data_tx_valid(spi_data_tx_valid),
    .spi_data_tx_ready(spi_data_tx_ready), .spi_start(spi_start), .spi_eot(spi_eot),
    .spi_csn(spi_csn), .fifo_overflow(fifo_overflow)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check any handshake against the model head, then apply a push
  task automatic step(input bit push, input logic [31:0] d);
    if (PRESET) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (spi_data_tx_valid && spi_data_tx_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $error("FAIL unexpected_pop observed=%h expected=none", spi_data_tx);
        end else begin
          chk("pop_data", spi_data_tx, q[0]);
          void'(q.pop_front());
        end
      end
      if (push) begin
        if (q.size() < DEPTH) q.push_back(d);
        else ovf_m = 1'b1;
      end
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    step(1'b0, '0);
    PENABLE = 1'b1;
    step(a == REG_TXFIFO, d);
    if (a == REG_CMD && d[1]) ovf_m = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic status(input string tag, input bit busy_e);
    logic [31:0] exp;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = REG_STATUS;
    #1;
    exp = {26'b0, 4'(q.size()), busy_e, ovf_m};
    chk(tag, PRDATA, exp);
    PSEL = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int pushes;
    PRESET = 1'b1; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PWDATA = '0; spi_data_tx_ready = 1'b0; spi_eot = 1'b0;
    step(1'b0, '0);
    step(1'b0, '0);
    PRESET = 1'b0;

    // Reset state
    chk("rst_csn", 32'(spi_csn), 32'd1);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_valid", 32'(spi_data_tx_valid), 32'd0);
    chk("rst_tx", spi_data_tx, 32'd0);
    chk("rst_ovf", 32'(fifo_overflow), 32'd0);
    chk("pready", 32'(PREADY), 32'd1);
    status("rst_status", 1'b0);
    PSEL = 1'b1; PADDR = REG_TXFIFO; #1;
    chk("rd_other_addr", PRDATA, 32'd0);
    PSEL = 1'b0;

    // Strobe without PWRITE, then wrong address: no push
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = REG_TXFIFO; PWDATA = 32'hA5A5_0001;
    step(1'b0, '0);
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_write(4'b0111, 32'hA5A5_0001);
    status("no_push", 1'b0);

    // Start with empty FIFO is ignored
    apb_write(REG_CMD, 32'd1);
    chk("empty_start_csn", 32'(spi_csn), 32'd1);
    chk("empty_start_pulse", 32'(spi_start), 32'd0);
    step(1'b0, '0);
    chk("empty_start_csn2", 32'(spi_csn), 32'd1);
    status("empty_start_idle", 1'b0);

    // Two-word transfer with ready high
    spi_data_tx_ready = 1'b1;
    apb_write(REG_TXFIFO, 32'h11);
    apb_write(REG_TXFIFO, 32'h22);
    apb_write(REG_CMD, 32'd1);
    chk("setup_start", 32'(spi_start), 32'd1);
    chk("setup_csn", 32'(spi_csn), 32'd0);
    chk("setup_valid", 32'(spi_data_tx_valid), 32'd0);
    step(1'b0, '0);
    chk("send_start_low", 32'(spi_start), 32'd0);
    chk("send_valid", 32'(spi_data_tx_valid), 32'd1);
    chk("send_w0", spi_data_tx, 32'h11);
    step(1'b0, '0);
    chk("send_w1", spi_data_tx, 32'h22);
    step(1'b0, '0);
    chk("wait_valid", 32'(spi_data_tx_valid), 32'd0);
    chk("wait_csn", 32'(spi_csn), 32'd0);
    status("wait_status", 1'b1);
    step(1'b0, '0);
    step(1'b0, '0);
    chk("wait_csn_held", 32'(spi_csn), 32'd0);
    spi_eot = 1'b1;
    step(1'b0, '0);
    spi_eot = 1'b0;
    chk("hold_csn", 32'(spi_csn), 32'd0);
    step(1'b0, '0);
    chk("idle_csn", 32'(spi_csn), 32'd1);
    status("idle_after_xfer", 1'b0);

    // Overflow: five random pushes into a depth-4 FIFO
    spi_data_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      apb_write(REG_TXFIFO, d);
    end
    chk("ovf_flag", 32'(fifo_overflow), 32'd1);
    status("ovf_status", 1'b0);
    apb_write(REG_CMD, 32'd2);
    status("ovf_cleared", 1'b0);

    // Back-pressure with full FIFO, then push+pop at full
    apb_write(REG_CMD, 32'd1);
    step(1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      chk("stall_valid", 32'(spi_data_tx_valid), 32'd1);
      chk("stall_data", spi_data_tx, q[0]);
      step(1'b0, '0);
    end
    d = $urandom;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = REG_TXFIFO; PWDATA = d;
    step(1'b0, '0);
    PENABLE = 1'b1; spi_data_tx_ready = 1'b1;
    step(1'b1, d);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; spi_data_tx_ready = 1'b0;
    chk("full_pp_ovf", 32'(fifo_overflow), 32'd0);
    status("full_pp_status", 1'b1);

    // Randomized drain with pushes extending the transfer
    pushes = 0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      chk("drain_csn", 32'(spi_csn), 32'd0);
      spi_data_tx_ready = 1'($urandom);
      if (pushes < 3 && q.size() >= 3 && ($urandom % 3 == 0)) begin
        d = $urandom;
        apb_write(REG_TXFIFO, d);
        pushes++;
      end else begin
        step(1'b0, '0);
      end
    end
    chk("drained", 32'(q.size()), 32'd0);
    chk("drain_wait_valid", 32'(spi_data_tx_valid), 32'd0);
    chk("drain_wait_csn", 32'(spi_csn), 32'd0);
    spi_eot = 1'b1;
    step(1'b0, '0);
    spi_eot = 1'b0;
    step(1'b0, '0);
    chk("drain_idle_csn", 32'(spi_csn), 32'd1);

    // Reset during WAIT_EOT with two words queued
    spi_data_tx_ready = 1'b1;
    apb_write(REG_TXFIFO, $urandom);
    apb_write(REG_TXFIFO, $urandom);
    apb_write(REG_CMD, 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      step(1'b0, '0);
    end
    chk("r_drained", 32'(q.size()), 32'd0);
    apb_write(REG_TXFIFO, $urandom);
    apb_write(REG_TXFIFO, $urandom);
    status("r_wait_status", 1'b1);
    chk("r_wait_csn", 32'(spi_csn), 32'd0);
    PRESET = 1'b1; spi_eot = 1'b1;
    step(1'b0, '0);
    PRESET = 1'b0; spi_eot = 1'b0;
    chk("r_csn", 32'(spi_csn), 32'd1);
    chk("r_valid", 32'(spi_data_tx_valid), 32'd0);
    chk("r_start", 32'(spi_start), 32'd0);
    chk("r_tx", spi_data_tx, 32'd0);
    status("r_status", 1'b0);
    step(1'b0, '0);
    chk("r_csn_stays", 32'(spi_csn), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
